// File: rtl/modulo_varredura_matriz_if.sv
// Scan coordinate bus between the matrix scan generator and the
// demultiplexer selector stage.
// Handshake: there is no back-pressure. en is a level-sensitive request
// from the consumer side. The producer qualifies every (mdc, mdl) pair
// with sel_valid, and the consumer must ignore mdc/mdl whenever
// sel_valid is low. fim_quadro is a one-cycle pulse that is valid
// regardless of sel_valid. estado mirrors the scan FSM for observation.
interface modulo_varredura_matriz_if;
   logic       en;
   logic [2:0] mdc;
   logic [2:0] mdl;
   logic       sel_valid;
   logic       fim_quadro;
   logic [1:0] estado;

   modport master (
      input  en,
      output mdc, mdl, sel_valid, fim_quadro, estado
   );

   modport slave (
      output en,
      input  mdc, mdl, sel_valid, fim_quadro, estado
   );
endinterface

// File: rtl/modulo_varredura_matriz.sv
// LED matrix scan generator. It walks the rows of each column with a
// prescaled dwell. It can insert blanking ticks between columns and
// pulses fim_quadro on the first cycle of every new frame.
module modulo_varredura_matriz #(
   parameter int DIV   = 4,
   parameter int N_COL = 5,
   parameter int N_LIN = 7,
   parameter int BLANK = 1
) (
   input  logic                           clk,
   input  logic                           clr,
   modulo_varredura_matriz_if.master      bus
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_BLANK = 2'd2
   } estado_t;

   estado_t       estado;
   logic [PW-1:0] pre;
   logic [3:0]    bcnt;
   logic [2:0]    col;
   logic [2:0]    lin;
   logic          valid;
   logic          fim;
   logic          tick;

   // A tick closes one dwell period. It is never raised while idle.
   assign tick = (estado != S_IDLE) && (int'(pre) == DIV - 1);

   assign bus.mdc        = col;
   assign bus.mdl        = lin;
   assign bus.sel_valid  = valid;
   assign bus.fim_quadro = fim;
   assign bus.estado     = estado;

   // Scan FSM with prescaler, row/column counters and registered outputs.
   always_ff @(posedge clk) begin
      if (clr || !bus.en) begin
         // Reset and enable drop share one path. An abort never pulses fim.
         estado <= S_IDLE;
         pre    <= '0;
         bcnt   <= '0;
         col    <= '0;
         lin    <= '0;
         valid  <= 1'b0;
         fim    <= 1'b0;
      end else begin
         fim <= 1'b0;
         pre <= tick ? '0 : pre + PW'(1);
         case (estado)
            S_IDLE: begin
               estado <= S_SCAN;
               pre    <= '0;
               col    <= '0;
               lin    <= '0;
               valid  <= 1'b1;
            end
            S_SCAN: begin
               if (tick) begin
                  if (int'(lin) < N_LIN - 1) begin
                     lin <= lin + 3'd1;
                  end else begin
                     lin <= '0;
                     if (BLANK > 0) begin
                        estado <= S_BLANK;
                        valid  <= 1'b0;
                        bcnt   <= '0;
                     end else if (int'(col) < N_COL - 1) begin
                        col <= col + 3'd1;
                     end else begin
                        col <= '0;
                        fim <= 1'b1;
                     end
                  end
               end
            end
            S_BLANK: begin
               if (tick) begin
                  if (int'(bcnt) < BLANK - 1) begin
                     bcnt <= bcnt + 4'd1;
                  end else begin
                     estado <= S_SCAN;
                     valid  <= 1'b1;
                     bcnt   <= '0;
                     if (int'(col) < N_COL - 1) begin
                        col <= col + 3'd1;
                     end else begin
                        col <= '0;
                        fim <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               // An unreachable encoding falls back to a clean idle.
               estado <= S_IDLE;
               pre    <= '0;
               bcnt   <= '0;
               col    <= '0;
               lin    <= '0;
               valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Bench for the matrix scan generator. Two instances run side by side:
// A uses the defaults (DIV=4, BLANK=1), and B uses DIV=1, BLANK=0.
// Expected outputs come from a closed-form frame-position model.
module tb_modulo_varredura_matriz;

   logic clk;
   logic clr;

   modulo_varredura_matriz_if ia ();
   modulo_varredura_matriz_if ib ();

   modulo_varredura_matriz dut_a (
      .clk (clk),
      .clr (clr),
      .bus (ia.master)
   );

   modulo_varredura_matriz #(.DIV(1), .N_COL(5), .N_LIN(7), .BLANK(0)) dut_b (
      .clk (clk),
      .clr (clr),
      .bus (ib.master)
   );

   // Clock and reset block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;
   int ta;
   int tb;
   logic [7:0] exp_qa[$];
   logic [7:0] exp_qb[$];

   typedef struct {
      int         t;
      logic [7:0] exp;
   } cp_t;
   cp_t cps[11];

   // Expected output packed as {sel_valid, fim_quadro, mdc, mdl}.
   // t is the number of cycles since the first SCAN cycle; a negative t means idle.
   function automatic logic [7:0] model(input int t, input int div, input int ncol,
                                        input int nlin, input int blank);
      int per_col;
      int p;
      int c;
      int r;
      logic [2:0] c3;
      logic [2:0] r3;
      if (t < 0) return 8'h00;
      per_col = (nlin + blank) * div;
      p = t % (ncol * per_col);
      c = p / per_col;
      r = (p % per_col) / div;
      c3 = c[2:0];
      r3 = r[2:0];
      if (r < nlin) return {1'b1, (t > 0) && (p == 0), c3, r3};
      return {2'b00, c3, 3'd0};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s ta=%0d tb=%0d act=%h exp=%h", name, ta, tb, act, exp);
      end
   endtask

   function automatic logic [7:0] act_a();
      return {ia.sel_valid, ia.fim_quadro, ia.mdc, ia.mdl};
   endfunction

   function automatic logic [7:0] act_b();
      return {ib.sel_valid, ib.fim_quadro, ib.mdc, ib.mdl};
   endfunction

   // Driver: apply one cycle of inputs, push expectations, sample at negedge.
   task automatic step(input logic c, input logic ea, input logic eb);
      clr   = c;
      ia.en = ea;
      ib.en = eb;
      ta = (c || !ea) ? -1 : ((ta < 0) ? 0 : ta + 1);
      tb = (c || !eb) ? -1 : ((tb < 0) ? 0 : tb + 1);
      exp_qa.push_back(model(ta, 4, 5, 7, 1));
      exp_qb.push_back(model(tb, 1, 5, 7, 0));
      @(posedge clk);
      @(negedge clk);
      check("sb_a", act_a(), exp_qa.pop_front());
      check("sb_b", act_b(), exp_qb.pop_front());
   endtask

   // Run DUT A until its frame position reaches pos, bounded by a cycle budget.
   task automatic run_to(input int pos, input string name);
      int k;
      k = 0;
      while ((ta < 0 || (ta % 160) != pos) && k < 400) begin
         step(1'b0, 1'b1, 1'b1);
         k++;
      end
      n_cmp++;
      if (k >= 400) begin
         n_bad++;
         $display("FAIL %s timeout act=%0d exp=%0d", name, ta, pos);
      end
   endtask

   int valid_cnt;
   int fim_cnt_a;
   int b_low;
   int b_last_fim;
   int hold;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ta = -1;
      tb = -1;
      clr = 1'b1;
      ia.en = 1'b1;
      ib.en = 1'b1;

      cps[0]  = '{0,   8'h80};
      cps[1]  = '{3,   8'h80};
      cps[2]  = '{4,   8'h81};
      cps[3]  = '{27,  8'h86};
      cps[4]  = '{28,  8'h00};
      cps[5]  = '{31,  8'h00};
      cps[6]  = '{32,  8'h88};
      cps[7]  = '{148, 8'hA5};
      cps[8]  = '{159, 8'h20};
      cps[9]  = '{160, 8'hC0};
      cps[10] = '{161, 8'h80};

      // Reset held with en high: outputs zero and FSM idle.
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("rst_out_a", act_a(), 8'h00);
      check("rst_state_a", {6'd0, ia.estado}, 8'h00);

      // Release: first coordinate appears one cycle later.
      step(1'b0, 1'b1, 1'b1);
      check("first_valid_a", act_a(), 8'h80);
      check("first_valid_b", act_b(), 8'h80);

      // Free run over two frames of A, checking fixed points and frame counts.
      valid_cnt = 0;
      fim_cnt_a = 0;
      b_low = 0;
      b_last_fim = -1;
      for (int i = 0; i < 330; i++) begin
         step(1'b0, 1'b1, 1'b1);
         foreach (cps[j]) begin
            if (cps[j].t == ta) check($sformatf("cp_t%0d", cps[j].t), act_a(), cps[j].exp);
         end
         if (ta >= 160 && ta < 320 && ia.sel_valid) valid_cnt++;
         if (ia.fim_quadro) fim_cnt_a++;
         if (!ib.sel_valid) b_low++;
         if (ib.fim_quadro) begin
            if (b_last_fim >= 0) check("b_fim_period", 8'(tb - b_last_fim), 8'd35);
            b_last_fim = tb;
         end
      end
      check("valid_slots_frame", 8'(valid_cnt / 4), 8'd35);
      check("fim_count_a", 8'(fim_cnt_a), 8'd2);
      check("b_never_blank", 8'(b_low), 8'd0);

      // Abort at (3,4): outputs zero, no fim, then restart with full dwell.
      run_to(112, "reach_3_4");
      check("at_3_4", act_a(), 8'h9C);
      step(1'b0, 1'b0, 1'b1);
      check("abort_out", act_a(), 8'h00);
      check("abort_state", {6'd0, ia.estado}, 8'h00);
      hold = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (act_a() == 8'h80) hold++;
      end
      check("restart_hold", 8'(hold), 8'd4);

      // clr together with en in the middle of a blanking interval.
      run_to(29, "reach_blank");
      check("in_blank", act_a(), 8'h00);
      check("blank_state", {6'd0, ia.estado}, 8'h02);
      step(1'b1, 1'b1, 1'b1);
      check("clr_blank_out", act_a(), 8'h00);
      check("clr_blank_state", {6'd0, ia.estado}, 8'h00);
      step(1'b0, 1'b1, 1'b1);
      check("resume_origin", act_a(), 8'h80);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1);

      check("queues_drained", 8'(exp_qa.size() + exp_qb.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
